// File: rtl/lock_sequencer_pkg.sv
// lock_pkg: shared types and defaults for the lock sequencer slice.
//   state_t       - sequencer state (IDLE, UNLOCKED, LOCKOUT), 2-bit encoding
//   DEF_*         - default parameter values
//   fail_w()      - width of the consecutive-failure counter
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;

  localparam int unsigned DEF_MAX_FAILS      = 3;
  localparam int unsigned DEF_UNLOCK_CYCLES  = 1000;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 5000;
  localparam int unsigned DEF_TIMER_W        = 16;

  // Bits needed to hold 0..max_fails.
  function automatic int unsigned fail_w(input int unsigned max_fails);
    return $clog2(max_fails + 1);
  endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// lock_sequencer_if: attempt handshake between the password comparator and
// the lock sequencer.
//   cmp_valid    - one-cycle strobe, cmp_mismatch is valid this cycle
//   cmp_mismatch - 0 = password matched, 1 = wrong password
//   ready        - sequencer will accept an attempt
// master = comparator side, slave = sequencer side.
interface lock_sequencer_if;
  logic cmp_valid;
  logic cmp_mismatch;
  logic ready;

  modport master (output cmp_valid, output cmp_mismatch, input ready);
  modport slave  (input cmp_valid, input cmp_mismatch, output ready);
endinterface

// File: rtl/lock_sequencer_timer.sv
// lock_timer: loadable down-counter shared by the UNLOCKED and LOCKOUT
// intervals. Stops at zero rather than wrapping.
//   clk, reset - clock, synchronous active-high reset (count -> 0)
//   load       - load load_val (has priority over en)
//   load_val   - value to load
//   en         - decrement while non-zero
//   zero       - count == 0
module lock_timer
  import lock_pkg::*;
#(
  parameter int unsigned TIMER_W = DEF_TIMER_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - TIMER_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: consumes comparator results, drives a timed unlock pulse,
// counts consecutive failures and enforces a timed lockout.
//   clk, reset  - clock, synchronous active-high reset
//   cmp         - attempt handshake (cmp_valid, cmp_mismatch, ready)
//   relock      - early relock while unlocked
//   alarm_ack   - clears alarm (optional feature only)
//   unlock      - actuator enable, UNLOCK_CYCLES long
//   locked_out  - high for LOCKOUT_CYCLES after MAX_FAILS consecutive misses
//   fail_count  - consecutive failures, saturating at MAX_FAILS
//   alarm       - intrusion alarm
// Optional feature: define LOCK_SEQUENCER_ALARM_EN to latch alarm on lockout
// entry until alarm_ack; otherwise alarm is constant 0.
// All outputs are registered from the next-state decode.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
  parameter int unsigned UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int unsigned TIMER_W        = DEF_TIMER_W
) (
  input  logic                           clk,
  input  logic                           reset,
  lock_sequencer_if.slave                cmp,
  input  logic                           relock,
  input  logic                           alarm_ack,
  output logic                           unlock,
  output logic                           locked_out,
  output logic [fail_w(MAX_FAILS)-1:0]   fail_count,
  output logic                           alarm
);

  localparam int unsigned FAIL_W = fail_w(MAX_FAILS);
  localparam logic [FAIL_W-1:0] MAX_F = FAIL_W'(MAX_FAILS);

  if (MAX_FAILS < 1 ||
      UNLOCK_CYCLES < 1 || longint'(UNLOCK_CYCLES) >= (longint'(1) << TIMER_W) ||
      LOCKOUT_CYCLES < 1 || longint'(LOCKOUT_CYCLES) >= (longint'(1) << TIMER_W)) begin : g_param_check
    $error("lock_sequencer: illegal parameter combination");
  end

  state_t              state, next_state;
  logic [FAIL_W-1:0]   fail_next;
  logic [FAIL_W-1:0]   fail_inc;
  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;
  logic                tmr_zero;

  lock_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (state != IDLE),
    .zero     (tmr_zero)
  );

  // fail_count never exceeds MAX_FAILS-1 while in IDLE, so this cannot wrap.
  assign fail_inc = fail_count + FAIL_W'(1);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    fail_next  = fail_count;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      IDLE: begin
        if (cmp.cmp_valid) begin
          if (!cmp.cmp_mismatch) begin
            next_state = UNLOCKED;
            fail_next  = '0;
            tmr_load   = 1'b1;
            tmr_val    = TIMER_W'(UNLOCK_CYCLES - 1);
          end else if (fail_inc == MAX_F) begin
            next_state = LOCKOUT;
            fail_next  = MAX_F;
            tmr_load   = 1'b1;
            tmr_val    = TIMER_W'(LOCKOUT_CYCLES - 1);
          end else begin
            fail_next  = fail_inc;
          end
        end
      end
      UNLOCKED: begin
        if (tmr_zero || relock)
          next_state = IDLE;
      end
      LOCKOUT: begin
        if (tmr_zero) begin
          next_state = IDLE;
          fail_next  = '0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp.ready  <= 1'b1;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
      fail_count <= '0;
    end else begin
      cmp.ready  <= (next_state == IDLE);
      unlock     <= (next_state == UNLOCKED);
      locked_out <= (next_state == LOCKOUT);
      fail_count <= fail_next;
    end
  end

`ifdef LOCK_SEQUENCER_ALARM_EN
  // Lockout entry takes priority over a coincident acknowledge.
  always_ff @(posedge clk) begin
    if (reset)
      alarm <= 1'b0;
    else if (state == IDLE && next_state == LOCKOUT)
      alarm <= 1'b1;
    else if (alarm_ack)
      alarm <= 1'b0;
  end
`else
  logic unused_alarm_ack;
  assign unused_alarm_ack = alarm_ack;
  assign alarm = 1'b0;
`endif

endmodule
